// File: rtl/dma_datapath_prims.sv
// Purpose: DMA datapath primitives -- rewindable FWFT FIFO, loadable up-counter, enabled register.
// Latency: one clk for every state update; FIFO data and all flags are combinational from state.
// Backpressure: none; push when full / pop when empty is dropped, the DMA FSM watches the flags.
//
// Ports:
//   clk, rst (async, active-low)                     shared by all three slices
//   fifo_rst/fifo_enable/fifo_wr_rd/fifo_old_add_flag FIFO controls; fifo_in/fifo_out data
//   full/empty/empty_partial                          FIFO occupancy flags
//   cnt_rst/cnt_en/cnt_load/cnt_data_in -> cnt, end_cnt
//   reg_rst/reg_en/reg_data_in -> reg_data_out
module dma_datapath_prims #(
    parameter int DATA       = 16,
    parameter int ADDR_SIZE  = 5,
    parameter int DIV_FACTOR = 3,
    parameter int CNT_L      = 15,
    parameter int REG_DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_rst,
    input  logic                 fifo_enable,
    input  logic                 fifo_wr_rd,
    input  logic                 fifo_old_add_flag,
    input  logic [DATA-1:0]      fifo_in,
    output logic [DATA-1:0]      fifo_out,
    output logic                 full,
    output logic                 empty,
    output logic                 empty_partial,
    input  logic                 cnt_rst,
    input  logic                 cnt_en,
    input  logic                 cnt_load,
    input  logic [CNT_L-1:0]     cnt_data_in,
    output logic [CNT_L-1:0]     cnt,
    output logic                 end_cnt,
    input  logic                 reg_rst,
    input  logic                 reg_en,
    input  logic [REG_DEPTH-1:0] reg_data_in,
    output logic [REG_DEPTH-1:0] reg_data_out
);

    localparam int                 DEPTH     = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_OCC = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] PART_THR  = DEPTH_OCC >> DIV_FACTOR;
    localparam logic [ADDR_SIZE:0] OCC_ONE   = (ADDR_SIZE+1)'(1);
    localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);
    localparam logic [CNT_L-1:0]   CNT_ONE   = CNT_L'(1);

    // ---------------- FIFO ----------------
    logic [DATA-1:0]      mem [DEPTH];
    logic [ADDR_SIZE-1:0] rd_ptr, wr_ptr;
    logic [ADDR_SIZE:0]   occ;
    logic                 do_wr, do_rd, rew_wr, rew_rd;

    assign full          = (occ == DEPTH_OCC);
    assign empty         = (occ == '0);
    assign empty_partial = (occ <= PART_THR);
    assign fifo_out      = mem[rd_ptr];

    // The rewind request wins over a normal access in the same cycle.
    assign do_wr  = !fifo_old_add_flag && fifo_enable &&  fifo_wr_rd && !full;
    assign do_rd  = !fifo_old_add_flag && fifo_enable && !fifo_wr_rd && !empty;
    // Write-side rewind needs a word to discard; read-side rewind needs a free slot to re-present.
    assign rew_wr =  fifo_old_add_flag &&  fifo_wr_rd && !empty;
    assign rew_rd =  fifo_old_add_flag && !fifo_wr_rd && !full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (fifo_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (do_wr) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            occ    <= occ + OCC_ONE;
        end else if (do_rd) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            occ    <= occ - OCC_ONE;
        end else if (rew_wr) begin
            wr_ptr <= wr_ptr - PTR_ONE;
            occ    <= occ - OCC_ONE;
        end else if (rew_rd) begin
            rd_ptr <= rd_ptr - PTR_ONE;
            occ    <= occ + OCC_ONE;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!fifo_rst && do_wr) begin
            mem[wr_ptr] <= fifo_in;
        end
    end

    // ---------------- Counter ----------------
    assign end_cnt = (cnt == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt_rst) begin
            cnt <= '0;
        end else if (cnt_en) begin
            cnt <= cnt_load ? cnt_data_in : cnt + CNT_ONE;
        end
    end

    // ---------------- Register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_data_out <= '0;
        end else if (reg_rst) begin
            reg_data_out <= '0;
        end else if (reg_en) begin
            reg_data_out <= reg_data_in;
        end
    end

endmodule

// File: tb/tb_dma_datapath_prims.sv
// Purpose: directed self-checking bench for dma_datapath_prims.
// Latency: inputs change 1ns after a rising edge, outputs are checked 1ns after the next one.
// Backpressure: none in the design; flags are checked directly.
module tb_dma_datapath_prims;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_rst, fifo_enable, fifo_wr_rd, fifo_old_add_flag;
    logic [15:0] fifo_in, fifo_out;
    logic        full, empty, empty_partial;
    logic        cnt_rst, cnt_en, cnt_load;
    logic [14:0] cnt_data_in, cnt;
    logic        end_cnt;
    logic        reg_rst, reg_en;
    logic [15:0] reg_data_in, reg_data_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dma_datapath_prims dut (
        .clk               (clk),
        .rst               (rst),
        .fifo_rst          (fifo_rst),
        .fifo_enable       (fifo_enable),
        .fifo_wr_rd        (fifo_wr_rd),
        .fifo_old_add_flag (fifo_old_add_flag),
        .fifo_in           (fifo_in),
        .fifo_out          (fifo_out),
        .full              (full),
        .empty             (empty),
        .empty_partial     (empty_partial),
        .cnt_rst           (cnt_rst),
        .cnt_en            (cnt_en),
        .cnt_load          (cnt_load),
        .cnt_data_in       (cnt_data_in),
        .cnt               (cnt),
        .end_cnt           (end_cnt),
        .reg_rst           (reg_rst),
        .reg_en            (reg_en),
        .reg_data_in       (reg_data_in),
        .reg_data_out      (reg_data_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        fifo_enable = 1'b1; fifo_wr_rd = 1'b1; fifo_in = d;
        tick();
        fifo_enable = 1'b0;
    endtask

    task automatic pop();
        fifo_enable = 1'b1; fifo_wr_rd = 1'b0;
        tick();
        fifo_enable = 1'b0;
    endtask

    task automatic rewind(input logic wr_side);
        fifo_old_add_flag = 1'b1; fifo_wr_rd = wr_side;
        fifo_enable = 1'b1;   // rewind must override a pending access
        tick();
        fifo_old_add_flag = 1'b0; fifo_enable = 1'b0;
    endtask

    task automatic fifo_clear();
        fifo_rst = 1'b1;
        tick();
        fifo_rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        fifo_rst = 0; fifo_enable = 0; fifo_wr_rd = 0; fifo_old_add_flag = 0; fifo_in = '0;
        cnt_rst = 0; cnt_en = 0; cnt_load = 0; cnt_data_in = '0;
        reg_rst = 0; reg_en = 0; reg_data_in = '0;
        #2;
        check("rst_empty",   32'(empty), 1);
        check("rst_epart",   32'(empty_partial), 1);
        check("rst_full",    32'(full), 0);
        check("rst_end_cnt", 32'(end_cnt), 0);
        check("rst_cnt",     32'(cnt), 0);
        check("rst_reg",     32'(reg_data_out), 0);
        tick();
        rst = 1'b1;
        tick();

        // ---- 1. asynchronous reset mid-operation ----
        cnt_en = 1; cnt_load = 1; cnt_data_in = 15'd9;
        reg_en = 1; reg_data_in = 16'h5555;
        push(16'hA001);
        cnt_en = 0; cnt_load = 0; reg_en = 0;
        push(16'hA002);
        push(16'hA003);
        check("pre_rst_cnt",   32'(cnt), 9);
        check("pre_rst_empty", 32'(empty), 0);
        check("pre_rst_reg",   32'(reg_data_out), 32'h5555);
        #1 rst = 1'b0;          // between edges
        #1;
        check("async_empty", 32'(empty), 1);
        check("async_cnt",   32'(cnt), 0);
        check("async_reg",   32'(reg_data_out), 0);
        #1 rst = 1'b1;
        tick();

        // ---- 2. fill / drain ----
        for (int i = 1; i <= 32; i++) begin
            push(16'(i));
            if (i == 31) check("full_at_31", 32'(full), 0);
        end
        check("full_at_32",  32'(full), 1);
        check("epart_at_32", 32'(empty_partial), 0);
        push(16'h00FF);
        check("full_after_33", 32'(full), 1);
        check("head_after_33", 32'(fifo_out), 32'h0001);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("drain_dat_%0d", i), 32'(fifo_out), 32'(i + 1));
            pop();
            check($sformatf("drain_epart_%0d", i), 32'(empty_partial), ((31 - i) <= 4) ? 1 : 0);
            check($sformatf("drain_empty_%0d", i), 32'(empty), (i == 31) ? 1 : 0);
        end
        pop();
        check("empty_after_extra_pop", 32'(empty), 1);
        push(16'h0BAD);           // rd_ptr must still equal wr_ptr
        check("ptr_after_extra_pop", 32'(fifo_out), 32'h0BAD);
        fifo_clear();
        check("fifo_rst_empty", 32'(empty), 1);

        // ---- 3. rewind ----
        push(16'h000A); push(16'h000B); push(16'h000C);
        rewind(1'b1);
        check("rew_head", 32'(fifo_out), 32'h000A);
        pop();
        check("rew_after_pop", 32'(fifo_out), 32'h000B);
        rewind(1'b0);
        check("rew_rd_head", 32'(fifo_out), 32'h000A);
        pop();
        check("rew_occ2_a", 32'(fifo_out), 32'h000B);
        check("rew_occ2_a_empty", 32'(empty), 0);
        pop();
        check("rew_occ2_empty", 32'(empty), 1);   // C was discarded
        rewind(1'b1);                             // occ = 0: ignored
        check("rew_underflow_empty", 32'(empty), 1);
        fifo_clear();

        // ---- 4. pointer wrap ----
        for (int i = 0; i < 20; i++) push(16'h0100 + 16'(i));
        for (int i = 0; i < 20; i++) begin
            check($sformatf("wrap1_%0d", i), 32'(fifo_out), 32'h0100 + 32'(i));
            pop();
        end
        for (int i = 0; i < 20; i++) push(16'h0200 + 16'(i));
        for (int i = 0; i < 20; i++) begin
            check($sformatf("wrap2_%0d", i), 32'(fifo_out), 32'h0200 + 32'(i));
            pop();
        end
        check("wrap_empty", 32'(empty), 1);

        // ---- 5. counter ----
        cnt_en = 1; cnt_load = 1; cnt_data_in = 15'h7FFD;
        tick();
        cnt_load = 0;
        check("cnt_load", 32'(cnt), 32'h7FFD);
        check("cnt_load_end", 32'(end_cnt), 0);
        tick(); tick();
        check("cnt_top", 32'(cnt), 32'h7FFF);
        check("cnt_top_end", 32'(end_cnt), 1);
        tick();
        check("cnt_wrap", 32'(cnt), 0);
        check("cnt_wrap_end", 32'(end_cnt), 0);
        cnt_en = 0; cnt_load = 1; cnt_data_in = 15'h1234;
        tick();
        cnt_load = 0;
        check("cnt_load_no_en", 32'(cnt), 0);
        cnt_en = 1;
        tick(); tick();
        check("cnt_count2", 32'(cnt), 2);
        cnt_rst = 1;
        tick();
        cnt_rst = 0; cnt_en = 0;
        check("cnt_rst", 32'(cnt), 0);

        // ---- 6. register ----
        reg_en = 1; reg_data_in = 16'hBEEF;
        tick();
        check("reg_cap", 32'(reg_data_out), 32'hBEEF);
        reg_en = 0; reg_data_in = 16'h1234;
        tick();
        check("reg_hold", 32'(reg_data_out), 32'hBEEF);
        check("reg_indep_cnt", 32'(cnt), 0);
        reg_rst = 1; reg_en = 1;
        tick();
        reg_rst = 0; reg_en = 0;
        check("reg_rst", 32'(reg_data_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
